// File: rtl/bsg_mem_banked_crossbar.sv
// Banked memory crossbar. Several requester ports share a set of single-port
// synchronous memory banks. Each bank has its own round-robin arbiter. Grants
// (yumi_o) are combinational, and read data returns one cycle after the grant.
module bsg_mem_banked_crossbar #(
    parameter int bank_size_p  = 1024,
    parameter int num_ports_p  = 2,
    parameter int num_banks_p  = 2,
    parameter int data_width_p = 32,
    localparam int word_bits_lp  = $clog2(bank_size_p),
    localparam int bank_bits_lp  = (num_banks_p == 1) ? 0 : $clog2(num_banks_p),
    localparam int addr_width_lp = word_bits_lp + bank_bits_lp,
    localparam int mask_width_lp = data_width_p / 8
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        reverse_pr_i,
    input  logic [num_ports_p-1:0]                      v_i,
    input  logic [num_ports_p-1:0]                      w_i,
    input  logic [num_ports_p-1:0][addr_width_lp-1:0]   addr_i,
    input  logic [num_ports_p-1:0][data_width_p-1:0]    data_i,
    input  logic [num_ports_p-1:0][mask_width_lp-1:0]   mask_i,
    output logic [num_ports_p-1:0]                      yumi_o,
    output logic [num_ports_p-1:0]                      v_o,
    output logic [num_ports_p-1:0][data_width_p-1:0]    data_o
);

    localparam int port_bits_lp = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
    localparam int bank_idx_lp  = (bank_bits_lp > 0) ? bank_bits_lp : 1;

    // Decoded address fields for each port.
    logic [num_ports_p-1:0][bank_idx_lp-1:0]  port_bank;
    logic [num_ports_p-1:0][word_bits_lp-1:0] port_word;

    // Per-bank arbitration result and the request routed to each bank.
    logic [num_banks_p-1:0]                    gnt_v;
    logic [num_banks_p-1:0][port_bits_lp-1:0]  gnt_port;
    logic [num_banks_p-1:0][port_bits_lp-1:0]  ptr_q, ptr_d;
    logic [num_banks_p-1:0]                    bank_we, bank_re;
    logic [num_banks_p-1:0][word_bits_lp-1:0]  bank_addr;
    logic [num_banks_p-1:0][data_width_p-1:0]  bank_wdata;
    logic [num_banks_p-1:0][mask_width_lp-1:0] bank_mask;
    logic [num_banks_p-1:0][data_width_p-1:0]  bank_rdata_q;

    // Read-return state for each port.
    logic [num_ports_p-1:0]                    v_q;
    logic [num_ports_p-1:0][bank_idx_lp-1:0]   sel_q;
    logic [num_ports_p-1:0][data_width_p-1:0]  hold_q;

    logic [data_width_p-1:0] mem_q [num_banks_p][bank_size_p];

    for (genvar p = 0; p < num_ports_p; p++) begin : g_decode
        assign port_word[p] = addr_i[p][word_bits_lp-1:0];
        if (num_banks_p > 1) begin : g_bank
            assign port_bank[p] = addr_i[p][addr_width_lp-1:word_bits_lp];
        end else begin : g_single
            assign port_bank[p] = '0;
        end
    end

    // Each bank scans its requesters from its pointer in the selected direction;
    // the first requester it finds wins, and the pointer moves one step past it.
    always_comb begin
        int   idx;
        logic found;
        logic [port_bits_lp-1:0] cand;
        gnt_v    = '0;
        gnt_port = '0;
        ptr_d    = ptr_q;
        idx      = 0;
        found    = 1'b0;
        cand     = '0;
        for (int b = 0; b < num_banks_p; b++) begin
            found = 1'b0;
            for (int k = 0; k < num_ports_p; k++) begin
                idx = reverse_pr_i ? (int'(ptr_q[b]) + num_ports_p - k) % num_ports_p
                                   : (int'(ptr_q[b]) + k) % num_ports_p;
                cand = port_bits_lp'(idx);
                // NOTE: yumi is gated by reset here, so grants drop as soon as reset asserts and do not wait for a clock edge.
                if (reset_i && !found && v_i[cand] && (port_bank[cand] == bank_idx_lp'(b))) begin
                    found       = 1'b1;
                    gnt_v[b]    = 1'b1;
                    gnt_port[b] = cand;
                    ptr_d[b]    = port_bits_lp'(reverse_pr_i ? (idx + num_ports_p - 1) % num_ports_p
                                                             : (idx + 1) % num_ports_p);
                end
            end
        end
    end

    // Acknowledge the winners and steer each winner's request into its bank.
    always_comb begin
        yumi_o     = '0;
        bank_we    = '0;
        bank_re    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        bank_mask  = '0;
        for (int b = 0; b < num_banks_p; b++) begin
            if (gnt_v[b]) begin
                yumi_o[gnt_port[b]] = 1'b1;
                bank_we[b]          = w_i[gnt_port[b]];
                bank_re[b]          = ~w_i[gnt_port[b]];
                bank_addr[b]        = port_word[gnt_port[b]];
                bank_wdata[b]       = data_i[gnt_port[b]];
                bank_mask[b]        = mask_i[gnt_port[b]];
            end
        end
    end

    // Bank storage with byte-masked writes and a registered read port.
    // NOTE: the memory and its read register have no reset; this lets the tools map them to SRAM, and their contents are undefined until written.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < num_banks_p; b++) begin
            if (bank_we[b]) begin
                for (int i = 0; i < mask_width_lp; i++) begin
                    if (bank_mask[b][i]) begin
                        mem_q[b][bank_addr[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                    end
                end
            end
            if (bank_re[b]) begin
                bank_rdata_q[b] <= mem_q[b][bank_addr[b]];
            end
        end
    end

    // Arbiter pointers and per-port read-valid tracking. All of this clears
    // asynchronously, so a read that is in flight when reset asserts is dropped.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q <= '0;
            v_q   <= '0;
            sel_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            v_q   <= yumi_o & ~w_i;
            sel_q <= port_bank;
        end
    end

    // Capture each completed read so data_o keeps its value while v_o is low.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < num_ports_p; p++) begin
            if (v_q[p]) begin
                hold_q[p] <= bank_rdata_q[sel_q[p]];
            end
        end
    end

    // Present fresh bank data on the return cycle, otherwise the held value.
    always_comb begin
        v_o = v_q;
        for (int p = 0; p < num_ports_p; p++) begin
            data_o[p] = v_q[p] ? bank_rdata_q[sel_q[p]] : hold_q[p];
        end
    end

endmodule

// File: tb/tb_bsg_mem_banked_crossbar.sv
// Self-checking bench for bsg_mem_banked_crossbar (3 ports, 3 banks, 1024 x 32).
// Each port has a queue of operations. A port keeps presenting the head of its
// queue until the reference model grants it. The model holds a flat copy of
// memory and one round-robin pointer per bank.
module tb_bsg_mem_banked_crossbar;

    localparam int NP = 3;
    localparam int NB = 3;
    localparam int BS = 1024;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 4;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   reverse_pr_i;
    logic [NP-1:0]          v_i, w_i;
    logic [NP-1:0][AW-1:0]  addr_i;
    logic [NP-1:0][DW-1:0]  data_i;
    logic [NP-1:0][MW-1:0]  mask_i;
    logic [NP-1:0]          yumi_o, v_o;
    logic [NP-1:0][DW-1:0]  data_o;

    always #5 clk_i = ~clk_i;

    bsg_mem_banked_crossbar #(
        .bank_size_p (BS),
        .num_ports_p (NP),
        .num_banks_p (NB),
        .data_width_p(DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .reverse_pr_i(reverse_pr_i),
        .v_i         (v_i),
        .w_i         (w_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .mask_i      (mask_i),
        .yumi_o      (yumi_o),
        .v_o         (v_o),
        .data_o      (data_o)
    );

    typedef struct packed {
        logic        w;
        logic [1:0]  bank;
        logic [9:0]  word;
        logic [31:0] data;
        logic [3:0]  mask;
    } op_t;

    op_t           port_q [NP][$];
    logic [31:0]   mdl_mem [NB][BS];
    int            ptr [NB];
    bit            have_last [NP];
    logic [31:0]   last_exp [NP];
    logic [31:0]   obs_last [NP];
    logic [NP-1:0] last_yumi;
    logic [NP-1:0] yumi_log [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_op(int p, logic w, int bank, int word, logic [31:0] data, logic [3:0] mask);
        op_t o;
        o.w    = w;
        o.bank = 2'(bank);
        o.word = 10'(word);
        o.data = data;
        o.mask = mask;
        port_q[p].push_back(o);
    endfunction

    function automatic void clear_model();
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        for (int p = 0; p < NP; p++) have_last[p] = 1'b0;
    endfunction

    function automatic bit queues_busy();
        return (port_q[0].size() + port_q[1].size() + port_q[2].size()) != 0;
    endfunction

    // Present each port's queue head; idle ports get random junk on the data lines.
    task automatic drive_heads();
        for (int p = 0; p < NP; p++) begin
            if (port_q[p].size() > 0) begin
                v_i[p]    = 1'b1;
                w_i[p]    = port_q[p][0].w;
                addr_i[p] = {port_q[p][0].bank, port_q[p][0].word};
                data_i[p] = port_q[p][0].data;
                mask_i[p] = port_q[p][0].mask;
            end else begin
                v_i[p]    = 1'b0;
                w_i[p]    = 1'($urandom);
                addr_i[p] = AW'($urandom);
                data_i[p] = $urandom;
                mask_i[p] = MW'($urandom);
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven. The model picks the winner
    // closest to each bank's pointer, measured in the scan direction. The bench
    // checks the grants mid-cycle and the read returns after the next edge.
    task automatic do_cycle();
        int          win [NB];
        int          bestd, d;
        logic [2:0]  exp_y;
        logic [2:0]  nv;
        logic [31:0] nd [NP];
        op_t         o;
        #2;
        exp_y = '0;
        nv    = '0;
        for (int p = 0; p < NP; p++) nd[p] = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            bestd  = NP;
            for (int p = 0; p < NP; p++) begin
                if (port_q[p].size() > 0 && int'(port_q[p][0].bank) == b) begin
                    d = reverse_pr_i ? (ptr[b] - p + NP) % NP : (p - ptr[b] + NP) % NP;
                    if (d < bestd) begin
                        bestd  = d;
                        win[b] = p;
                    end
                end
            end
            if (win[b] >= 0) exp_y[win[b]] = 1'b1;
        end
        last_yumi = yumi_o;
        yumi_log.push_back(yumi_o);
        check("yumi", yumi_o, exp_y);
        if (v_i != '0) check("any_grant", 32'(|yumi_o), 32'd1);
        for (int b = 0; b < NB; b++) begin
            if (win[b] >= 0) begin
                o = port_q[win[b]].pop_front();
                if (o.w) begin
                    for (int i = 0; i < MW; i++)
                        if (o.mask[i]) mdl_mem[b][o.word][8*i +: 8] = o.data[8*i +: 8];
                end else begin
                    nv[win[b]] = 1'b1;
                    nd[win[b]] = mdl_mem[b][o.word];
                end
                ptr[b] = reverse_pr_i ? (win[b] + NP - 1) % NP : (win[b] + 1) % NP;
            end
        end
        @(posedge clk_i);
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("v_o_p%0d", p), 32'(v_o[p]), 32'(nv[p]));
            if (v_o[p]) obs_last[p] = data_o[p];
            if (nv[p]) begin
                check($sformatf("rdata_p%0d", p), data_o[p], nd[p]);
                have_last[p] = 1'b1;
                last_exp[p]  = nd[p];
            end else if (have_last[p]) begin
                check($sformatf("hold_p%0d", p), data_o[p], last_exp[p]);
            end
        end
    endtask

    task automatic run_queues(input int max_cycles);
        int n = 0;
        while (queues_busy() && n < max_cycles) begin
            drive_heads();
            do_cycle();
            n++;
        end
        if (queues_busy()) begin
            check("timeout", 32'(port_q[0].size() + port_q[1].size() + port_q[2].size()), 32'd0);
            for (int p = 0; p < NP; p++) port_q[p].delete();
        end
    endtask

    // Reset applied at posedge+1 and released two edges later, at posedge+1.
    task automatic apply_reset();
        reset_i = 1'b0;
        for (int p = 0; p < NP; p++) port_q[p].delete();
        drive_heads();
        clear_model();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_v_o", 32'(v_o), 32'd0);
        reset_i = 1'b1;
    endtask

    task automatic check_conflict(input string tag, input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2);
        logic [2:0] exp_seq [3];
        logic [2:0] obs;
        exp_seq[0] = e0;
        exp_seq[1] = e1;
        exp_seq[2] = e2;
        for (int k = 0; k < 3; k++) begin
            obs = (k < yumi_log.size()) ? yumi_log[k] : 3'b000;
            check($sformatf("%s_c%0d", tag, k), 32'(obs), 32'(exp_seq[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] by;
        reset_i      = 1'b0;
        reverse_pr_i = 1'b0;
        clear_model();
        // Reset state: requests are presented but nothing may be granted.
        push_op(0, 1'b0, 0, 0, '0, '0);
        push_op(1, 1'b0, 1, 0, '0, '0);
        push_op(2, 1'b1, 2, 0, '0, 4'hF);
        drive_heads();
        #3;
        check("rst_yumi", 32'(yumi_o), 32'd0);
        check("rst_vo", 32'(v_o), 32'd0);
        for (int p = 0; p < NP; p++) port_q[p].delete();
        drive_heads();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_vo_clk", 32'(v_o), 32'd0);
        reset_i = 1'b1;

        // Fill: port i writes every word congruent to i mod 3 in every bank.
        for (int p = 0; p < NP; p++)
            for (int a = p; a < BS; a += NP)
                for (int k = 0; k < NB; k++) begin
                    by = {4'(p), 4'((k + p) % NB)};
                    push_op(p, 1'b1, (k + p) % NB, a, {4{by}}, 4'hF);
                end
        run_queues(1200);
        for (int p = 0; p < NP; p++)
            for (int a = p; a < BS; a += NP)
                for (int k = 0; k < NB; k++)
                    push_op(p, 1'b0, (k + p) % NB, a, $urandom, 4'($urandom));
        run_queues(1200);

        push_op(1, 1'b0, 2, 1, '0, '0);
        run_queues(10);
        check("fill_p1b2", obs_last[1], 32'h12121212);

        // Three ports to three distinct banks are all served together.
        push_op(0, 1'b0, 0, 3, '0, '0);
        push_op(1, 1'b0, 1, 4, '0, '0);
        push_op(2, 1'b0, 2, 5, '0, '0);
        drive_heads();
        do_cycle();
        check("tput3", 32'(last_yumi), 32'd7);

        // Byte mask, plus a read that immediately follows a write to the same word.
        push_op(0, 1'b1, 1, 5, 32'h01010101, 4'hF);
        push_op(0, 1'b1, 1, 5, 32'hFFFFFFFF, 4'h0);
        push_op(0, 1'b0, 1, 5, '0, '0);
        run_queues(20);
        check("mask0", obs_last[0], 32'h01010101);
        push_op(0, 1'b1, 1, 5, 32'hFFFFFFFF, 4'b0011);
        push_op(0, 1'b0, 1, 5, '0, '0);
        run_queues(20);
        check("mask3", obs_last[0], 32'h0101FFFF);

        // Same-bank conflict, ascending then descending scan from a reset pointer.
        apply_reset();
        reverse_pr_i = 1'b0;
        for (int p = 0; p < NP; p++) push_op(p, 1'b0, 0, p, '0, '0);
        yumi_log.delete();
        run_queues(10);
        check_conflict("conf_fwd", 3'b001, 3'b010, 3'b100);
        apply_reset();
        reverse_pr_i = 1'b1;
        for (int p = 0; p < NP; p++) push_op(p, 1'b0, 0, p, '0, '0);
        yumi_log.delete();
        run_queues(10);
        check_conflict("conf_rev", 3'b001, 3'b100, 3'b010);
        reverse_pr_i = 1'b0;

        // Reset asserted while a read result is on the outputs.
        push_op(0, 1'b0, 1, 7, '0, '0);
        drive_heads();
        do_cycle();
        #2;
        reset_i = 1'b0;
        #1;
        check("rst_vo_async", 32'(v_o[0]), 32'd0);
        clear_model();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        repeat (3) begin
            drive_heads();
            do_cycle();
        end

        // Reset asserted in the middle of a grant cycle, which aborts the read.
        push_op(2, 1'b0, 2, 9, '0, '0);
        drive_heads();
        #2;
        check("pre_rst_yumi", 32'(yumi_o), 32'd4);
        reset_i = 1'b0;
        #1;
        check("mid_rst_yumi", 32'(yumi_o), 32'd0);
        port_q[2].delete();
        clear_model();
        drive_heads();
        @(posedge clk_i);
        #1;
        check("abort_vo", 32'(v_o), 32'd0);
        reset_i = 1'b1;
        repeat (2) begin
            drive_heads();
            do_cycle();
        end
        push_op(2, 1'b0, 2, 9, '0, '0);
        run_queues(10);

        // Random traffic on a small address window to force frequent conflicts.
        for (int n = 0; n < 400; n++) begin
            reverse_pr_i = 1'($urandom);
            for (int p = 0; p < NP; p++)
                if (port_q[p].size() == 0 && $urandom_range(3, 0) != 0)
                    push_op(p, 1'($urandom), $urandom_range(NB - 1, 0), $urandom_range(15, 0),
                            $urandom, 4'($urandom));
            drive_heads();
            do_cycle();
        end
        run_queues(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
